// File: rtl/mips_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: operation encodings,
// sequencer states and the default datapath width.
package mips_pkg;

  localparam int XLEN_DEF = 32;

  typedef enum logic [1:0] {
    MD_MULTU = 2'b00,
    MD_MULT  = 2'b01,
    MD_DIVU  = 2'b10,
    MD_DIV   = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } md_state_e;

  function automatic logic md_is_div(input md_op_e o);
    return (o == MD_DIVU) || (o == MD_DIV);
  endfunction

  function automatic logic md_is_signed(input md_op_e o);
    return (o == MD_MULT) || (o == MD_DIV);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration on unsigned magnitudes: shift-add for multiply,
// restoring subtract-and-shift for divide. Purely combinational.
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN:0]   hi_i,
  input  logic [XLEN-1:0] lo_i,
  input  logic [XLEN-1:0] opnd_i,
  input  logic            is_div_i,
  output logic [XLEN:0]   hi_o,
  output logic [XLEN-1:0] lo_o
);

  logic [XLEN:0] sum;
  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;
  logic          qbit;

  // NOTE: every output gets a value on every path through always_comb;
  // a missing branch assignment would infer a latch.
  always_comb begin
    sum     = hi_i + (lo_i[0] ? {1'b0, opnd_i} : '0);
    shifted = {hi_i[XLEN-1:0], lo_i[XLEN-1]};
    diff    = shifted - {1'b0, opnd_i};
    qbit    = (shifted >= {1'b0, opnd_i});
    if (is_div_i) begin
      // Quotient bits enter at the bottom as dividend bits leave the top.
      hi_o = qbit ? diff : shifted;
      lo_o = {lo_i[XLEN-2:0], qbit};
    end else begin
      hi_o = {1'b0, sum[XLEN:1]};
      lo_o = {sum[0], lo_i[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// HI/LO multiply/divide sequencer: latches operands, runs XLEN iterations of
// muldiv_step, applies sign correction and raises stalls for early HI/LO reads.
module muldiv_sequencer
  import mips_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  input  logic            rd_hilo,
  output logic            busy,
  output logic            done,
  output logic            stall_req,
  output logic            div_by_zero,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  md_state_e       state_q;
  md_op_e          op_q;
  logic [CNT_W-1:0] cnt_q;
  logic [XLEN:0]   acc_hi_q;
  logic [XLEN-1:0] acc_lo_q;
  logic [XLEN-1:0] opnd_q;
  logic [XLEN-1:0] a_q;
  logic            neg_q;
  logic            rem_neg_q;
  logic            b_zero_q;
  logic [XLEN-1:0] hi_q;
  logic [XLEN-1:0] lo_q;
  logic            done_q;
  logic            dbz_q;

  md_op_e          op_in;
  logic            in_div;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic            op_is_div;
  logic [XLEN:0]   step_hi;
  logic [XLEN-1:0] step_lo;

  assign op_in  = md_op_e'(op);
  assign in_div = md_is_div(op_in);
  assign a_neg  = md_is_signed(op_in) & a[XLEN-1];
  assign b_neg  = md_is_signed(op_in) & b[XLEN-1];
  // An unsigned XLEN-bit magnitude holds 2^(XLEN-1) exactly, so -2^(XLEN-1) needs no special case.
  assign a_mag  = a_neg ? -a : a;
  assign b_mag  = b_neg ? -b : b;
  assign op_is_div = md_is_div(op_q);

  muldiv_step #(.XLEN(XLEN)) u_step (
    .hi_i     (acc_hi_q),
    .lo_i     (acc_lo_q),
    .opnd_i   (opnd_q),
    .is_div_i (op_is_div),
    .hi_o     (step_hi),
    .lo_o     (step_lo)
  );

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   fin_hi;
  logic [XLEN-1:0]   fin_lo;

  always_comb begin
    prod = {acc_hi_q[XLEN-1:0], acc_lo_q};
    if (neg_q) prod = -prod;
    quo    = neg_q ? -acc_lo_q : acc_lo_q;
    rem    = rem_neg_q ? -acc_hi_q[XLEN-1:0] : acc_hi_q[XLEN-1:0];
    fin_hi = prod[2*XLEN-1:XLEN];
    fin_lo = prod[XLEN-1:0];
    if (op_is_div) begin
      if (b_zero_q) begin
        fin_hi = a_q;
        fin_lo = '1;
      end else begin
        fin_hi = rem;
        fin_lo = quo;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      op_q      <= MD_MULTU;
      cnt_q     <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      opnd_q    <= '0;
      a_q       <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      b_zero_q  <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start && !flush) begin
            state_q   <= RUN;
            op_q      <= op_in;
            cnt_q     <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= in_div ? a_mag : b_mag;
            opnd_q    <= in_div ? b_mag : a_mag;
            a_q       <= a;
            neg_q     <= a_neg ^ b_neg;
            rem_neg_q <= a_neg;
            b_zero_q  <= (b == '0);
          end
        end
        RUN: begin
          if (flush) begin
            state_q <= IDLE;
          end else begin
            acc_hi_q <= step_hi;
            acc_lo_q <= step_lo;
            cnt_q    <= cnt_q + 1'b1;
            if (cnt_q == CNT_W'(XLEN - 1)) state_q <= FIN;
          end
        end
        FIN: begin
          state_q <= IDLE;
          if (!flush) begin
            hi_q   <= fin_hi;
            lo_q   <= fin_lo;
            done_q <= 1'b1;
            dbz_q  <= op_is_div & b_zero_q;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy        = (state_q != IDLE);
  assign stall_req   = rd_hilo & (busy | (start & (state_q == IDLE)));
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule
